// File: rtl/seq_det_pkg.sv
// Shared constants for the frame-level sequence detector: FSM encodings and
// power-on detector configuration.
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Alternating base pattern; any PAT_W up to 8 takes its low bits.
  localparam logic [7:0] PAT_BASE        = 8'hAA;
  localparam logic [3:0] PAT_DEFAULT     = 4'b1010;
  localparam logic       OVERLAP_DEFAULT = 1'b1;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial Mealy pattern matcher: keeps PAT_W-1 bits of history plus a
// count of how many of them are valid, and flags a match in the same cycle.
module seq_det_core #(
  parameter int PAT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             det
);

  localparam int HW = $clog2(PAT_W);
  localparam logic [HW-1:0] HMAX = HW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [HW-1:0]    hcnt_q;
  logic [PAT_W-1:0] win;

  assign win = {hist_q, bit_in};
  assign det = en && (hcnt_q == HMAX) && (win == pattern);

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      hist_q <= '0;
      hcnt_q <= '0;
    end else if (en) begin
      hist_q <= win[PAT_W-2:0];
      // Non-overlapping mode forgets the bits that formed the match.
      if (det && !overlap) begin
        hcnt_q <= '0;
      end else if (hcnt_q != HMAX) begin
        hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_frame_ctrl.sv
// Frame sequencer: accepts words over valid/ready, shifts them MSB-first into
// the detector core and counts matches per frame.
module seq_det_frame_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cfg_We,
  input  logic [PAT_W-1:0]  Cfg_Pattern,
  input  logic              Cfg_Overlap,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Last,
  output logic              Bit_Out,
  output logic              Det_Pulse,
  output logic [CNT_W-1:0]  Match_Cnt,
  output logic              Done,
  output logic [1:0]        State
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sreg_q;
  logic [BW-1:0]     bcnt_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              xfer;
  logic              shifting;
  logic              frame_start;

  assign In_Ready    = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign xfer        = In_Valid && In_Ready;
  assign shifting    = (state_q == ST_SHIFT);
  assign frame_start = (state_q == ST_IDLE) && xfer;
  assign Bit_Out     = shifting && sreg_q[DATA_W-1];
  assign Match_Cnt   = cnt_q;
  assign Done        = (state_q == ST_DONE);
  assign State       = state_q;

  seq_det_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (frame_start),
    .en      (shifting),
    .bit_in  (Bit_Out),
    .pattern (pat_q),
    .overlap (ovl_q),
    .det     (Det_Pulse)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_SHIFT;
      ST_SHIFT: if (bcnt_q == BIT_LAST) state_d = last_q ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (xfer) state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= PAT_BASE[PAT_W-1:0];
      ovl_q   <= OVERLAP_DEFAULT;
    end else begin
      state_q <= state_d;
      // Config is only writable between frames so a frame never sees it change.
      if ((state_q == ST_IDLE) && Cfg_We) begin
        pat_q <= Cfg_Pattern;
        ovl_q <= Cfg_Overlap;
      end
      if (xfer) begin
        sreg_q <= In_Data;
        last_q <= In_Last;
        bcnt_q <= '0;
      end else if (shifting) begin
        sreg_q <= sreg_q << 1;
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (frame_start) begin
        cnt_q <= '0;
      end else if (Det_Pulse && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Directed bench for seq_det_frame_ctrl: frames are pushed word by word and
// per-bit detector pulses are collected into a frame-wide mask.
module tb_seq_det_frame_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Cfg_We = 1'b0;
  logic [3:0] Cfg_Pattern = 4'b1010;
  logic       Cfg_Overlap = 1'b1;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [7:0] In_Data = 8'h00;
  logic       In_Last = 1'b0;
  logic       Bit_Out;
  logic       Det_Pulse;
  logic [3:0] Match_Cnt;
  logic       Done;
  logic [1:0] State;

  int checks = 0;
  int failures = 0;
  logic [63:0] pmask;
  int fbit;
  int done_seen;

  seq_det_frame_ctrl #(
    .DATA_W (8),
    .PAT_W  (4),
    .CNT_W  (4)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Cfg_We      (Cfg_We),
    .Cfg_Pattern (Cfg_Pattern),
    .Cfg_Overlap (Cfg_Overlap),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Data     (In_Data),
    .In_Last     (In_Last),
    .Bit_Out     (Bit_Out),
    .Det_Pulse   (Det_Pulse),
    .Match_Cnt   (Match_Cnt),
    .Done        (Done),
    .State       (State)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    pmask = '0;
    fbit = 0;
  endtask

  // Hands one word over, then samples its DATA_W serial bits.
  task automatic run_word(input string tag, input logic [7:0] data, input logic last,
                          input logic cfg_mid);
    logic [7:0] obs_bits;
    int guard;
    guard = 0;
    In_Valid = 1'b1;
    In_Data  = data;
    In_Last  = last;
    while (!In_Ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 64'(In_Ready), 64'd1);
    tick();
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    Cfg_We   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cfg_mid && i == 2) begin
        Cfg_We = 1'b1;
        Cfg_Pattern = 4'b1111;
        Cfg_Overlap = 1'b1;
      end else begin
        Cfg_We = 1'b0;
      end
      obs_bits[7-i] = Bit_Out;
      if (fbit < 64) pmask[fbit] = Det_Pulse;
      fbit++;
      tick();
    end
    Cfg_We = 1'b0;
    check({tag, "_bits"}, 64'(obs_bits), 64'(data));
  endtask

  task automatic check_done(input string tag, input logic [63:0] mask, input logic [3:0] cnt);
    check({tag, "_state"}, 64'(State), 64'd3);
    check({tag, "_done"}, 64'(Done), 64'd1);
    check({tag, "_mask"}, pmask, mask);
    check({tag, "_cnt"}, 64'(Match_Cnt), 64'(cnt));
    tick();
    check({tag, "_idle"}, 64'(State), 64'd0);
    check({tag, "_done_low"}, 64'(Done), 64'd0);
    check({tag, "_cnt_hold"}, 64'(Match_Cnt), 64'(cnt));
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    Rst = 1'b0;
    check("rst_state", 64'(State), 64'd0);
    check("rst_ready", 64'(In_Ready), 64'd1);
    check("rst_bit", 64'(Bit_Out), 64'd0);
    check("rst_det", 64'(Det_Pulse), 64'd0);
    check("rst_cnt", 64'(Match_Cnt), 64'd0);
    check("rst_done", 64'(Done), 64'd0);

    // Default config, overlapping: matches end on bits 4, 6, 8
    new_frame();
    run_word("aa_ovl", 8'hAA, 1'b1, 1'b0);
    check_done("aa_ovl", 64'hA8, 4'd3);

    // Non-overlap latched on the accepting edge: bits 4 and 8
    Cfg_We = 1'b1;
    Cfg_Pattern = 4'b1010;
    Cfg_Overlap = 1'b0;
    new_frame();
    run_word("aa_novl", 8'hAA, 1'b1, 1'b0);
    check_done("aa_novl", 64'h88, 4'd2);

    // History across words: 0000_0101 then 0000_0000, 1010 ends on frame bit 9
    Cfg_We = 1'b1;
    Cfg_Overlap = 1'b1;
    new_frame();
    run_word("xw0", 8'h05, 1'b0, 1'b0);
    check("xw_wait_state", 64'(State), 64'd2);
    check("xw_wait_done", 64'(Done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("xw_stall_ready", 64'(In_Ready), 64'd1);
      check("xw_stall_state", 64'(State), 64'd2);
      tick();
    end
    run_word("xw1", 8'h00, 1'b1, 1'b0);
    check_done("xw", 64'h100, 4'd1);

    // Saturation: 19 raw matches across five words clamp at 15
    new_frame();
    for (int w = 0; w < 5; w++) run_word("sat", 8'hAA, (w == 4), 1'b0);
    check_done("sat", 64'hAAAAAAAAA8, 4'd15);

    // Config write during SHIFT is ignored
    new_frame();
    run_word("cfg_mid", 8'hAA, 1'b1, 1'b1);
    check_done("cfg_mid", 64'hA8, 4'd3);

    // Same write in IDLE takes effect: 1111 on 8'hFF ends on bits 4..8
    Cfg_We = 1'b1;
    Cfg_Pattern = 4'b1111;
    Cfg_Overlap = 1'b1;
    tick();
    Cfg_We = 1'b0;
    new_frame();
    run_word("ff", 8'hFF, 1'b1, 1'b0);
    check_done("ff", 64'hF8, 4'd5);

    // Reset at bit 3 aborts the frame and restores the default config
    Cfg_We = 1'b1;
    Cfg_Pattern = 4'b0110;
    Cfg_Overlap = 1'b0;
    In_Valid = 1'b1;
    In_Data = 8'hAA;
    In_Last = 1'b1;
    tick();
    In_Valid = 1'b0;
    In_Last = 1'b0;
    Cfg_We = 1'b0;
    tick();
    tick();
    check("abort_shift", 64'(State), 64'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_state", 64'(State), 64'd0);
    check("abort_cnt", 64'(Match_Cnt), 64'd0);
    check("abort_ready", 64'(In_Ready), 64'd1);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) done_seen++;
      tick();
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    new_frame();
    run_word("post_rst", 8'hAA, 1'b1, 1'b0);
    check_done("post_rst", 64'hA8, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
